keccak_sequencer: RTL
=====================

// Module: keccak_sequencer
// PURPOSE
//  FSM sequencer for the cSHAKE sliced data path.
//  - Generates every data path control: absorb_data, absorb_cust, computation_en, round, reads, bof, squeeze_output, reset_ram, mux256.
//  - Upstream side: a valid/ready word interface for message input.
//  - Downstream side: a valid/ready word interface for digest output.
//  - Sits between the top-level cSHAKE wrapper and data_path; contains no datapath logic.
// PARAMETERS
//  PARALLEL_SLICES    16  slices processed per cycle; also the input word width
//  WOUT               32  output word width (must be a multiple of PARALLEL_SLICES)
//  NUM_SUB_ROUNDS     4   cycles per Keccak round (power of 2)
//  KECCAK_ROUNDS      24  rounds per permutation
//  ROUND_COUNT_WIDTH  7   width of round
//  COUNTER_WIDTH      8   width of reads
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   asynchronous active-low reset
//  start           in   1   pulse: begin a new hash (sampled in IDLE only)
//  mode256         in   1   0 = cSHAKE128 (rate 21 lanes = 84 words), 1 = cSHAKE256 (17 lanes = 68 words); latched at start
//  cust_en         in   1   latched at start; 1 = absorb a 4-word customization lane first
//  out_blocks      in   8   number of rate blocks to squeeze (0 is treated as 1); latched at start
//  in_data         in   16  message/customization word, forwarded to the data path din
//  in_valid        in   1   upstream word valid
//  in_last         in   1   marks the final word of the final block (already padded)
//  in_ready        out  1   word accepted when in_valid & in_ready
//  out_valid       out  1   dout holds a valid WOUT-bit word
//  out_ready       in   1   downstream accepts the word
//  busy            out  1   high whenever state != IDLE
//  done            out  1   one-cycle pulse when the final output word is accepted
//  dp_*            out  -   data path controls (see BEHAVIOUR); din mirrors in_data
// BEHAVIOUR
//  Reset values: all outputs 0; state = IDLE.
//  State sequence: IDLE -> CLEAR -> [CUST -> PERM] -> ABSORB -> PERM -> (ABSORB | SQUEEZE) -> ... -> IDLE
//  IDLE
//   - in_ready = 0.
//   - start -> CLEAR; latch mode256, cust_en, out_blocks.
//  CLEAR (exactly 1 cycle)
//   - reset_ram = 1.
//   - Next state: CUST if cust_en, else ABSORB.
//   - bof := 1.
//  CUST
//   - in_ready = 1.
//   - absorb_cust = in_valid. A word is written only on a cycle where it is accepted.
//   - reads increments per accepted word.
//   - After 4 accepted words: reads := 0 -> PERM; on return from PERM go to ABSORB with bof := 1.
//  ABSORB
//   - in_ready = 1.
//   - absorb_data = in_valid.
//   - bof stays high for the whole first block, then clears.
//   - reads increments per accepted word.
//   - Block end = accepted word with reads == rate_words-1, or accepted in_last.
//   - At block end: reads := 0 -> PERM.
//   - in_last before the rate boundary: the remaining lanes are not written; the bench must pre-pad.
//   - Stalls (in_valid = 0) hold all counters and drive no write enables.
//  PERM (96 + 1 cycles)
//   - computation_en = 1.
//   - round counts 0..95 with round>>2 selecting the Keccak round.
//   - One extra cycle at round = 96 performs the last-round write.
//   - Then round := 0 and the next state is taken:
//     - SQUEEZE if in_last was seen, or if more output blocks are pending;
//     - else ABSORB.
//  SQUEEZE
//   - squeeze_output = 1.
//   - reads steps through rate_words, advancing only while the output register is not full.
//   - Each group of WOUT/PARALLEL_SLICES = 2 reads completes a word.
//   - out_valid rises the cycle after that second read (data path output register latency 1).
//   - Word held stable while out_valid & !out_ready (no reads advance).
//   - Rate exhausted with blocks remaining -> PERM (computation_en, no input).
//   - Last word of the last block accepted -> done pulse -> IDLE.
//  Arithmetic rules
//   - rate_words = 84 (mode256 = 0) or 68 (mode256 = 1).
//   - reads wraps to 0 only via the explicit resets above, never by overflow.
//   - mux256 = latched mode256 for the whole hash.
//  Boundary conditions
//   - start while busy: ignored.
//   - in_valid in PERM/SQUEEZE: in_ready = 0, nothing consumed.
//   - in_last on the first word of a block: block closes after 1 word.
//   - rst_n low mid-operation: immediate return to IDLE, all outputs 0.
//     The next hash always passes through CLEAR, so no stale state survives.
// CONFIGURATION
//  KECCAK_SEQ_PERF_EN
//   - Defined: adds output perf_cycles[31:0].
//     - Cleared at start; increments every cycle while busy.
//     - Frozen at done until the next start.
//     - Also adds a saturating perf_perms[7:0] permutation counter.
//   - Undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
//  1. cSHAKE128, cust_en = 0, one 84-word block with in_last, out_blocks = 1, out_ready = 1:
//     -> 1 CLEAR + 84 ABSORB + 97 PERM cycles, then 42 out words, done, IDLE.
//  2. Same with mode256 = 1:
//     -> absorb closes after 68 words, 34 output words, mux256 = 1 throughout.
//  3. cust_en = 1:
//     -> 4 absorb_cust cycles, a 97-cycle PERM, then ABSORB with bof = 1 on all 84 words.
//  4. in_valid toggled 50%, out_ready held low 10 cycles mid-squeeze:
//     -> reads/round frozen during stalls; dout stable; digest matches the no-stall run.
//  5. out_blocks = 3:
//     -> 126 words out, 2 extra PERMs with no in_ready, done after word 126.
//  6. rst_n asserted during PERM round 40, then a new start:
//     -> outputs 0 immediately; the new hash digest equals the reference vector.

Source files
------------

// File: rtl/keccak_sequencer.sv
// Control FSM for the sliced cSHAKE data path: customization, absorb, permute and squeeze sequencing.
// Optional feature macro KECCAK_SEQ_PERF_EN adds the perf_cycles / perf_perms counters.
module keccak_sequencer #(
  parameter int PARALLEL_SLICES   = 16,
  parameter int WOUT              = 32,
  parameter int NUM_SUB_ROUNDS    = 4,
  parameter int KECCAK_ROUNDS     = 24,
  parameter int ROUND_COUNT_WIDTH = 7,
  parameter int COUNTER_WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode256,
  input  logic                         cust_en,
  input  logic [7:0]                   out_blocks,
  input  logic [PARALLEL_SLICES-1:0]   in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         dp_absorb_data,
  output logic                         dp_absorb_cust,
  output logic                         dp_computation_en,
  output logic [ROUND_COUNT_WIDTH-1:0] dp_round,
  output logic [COUNTER_WIDTH-1:0]     dp_reads,
  output logic                         dp_bof,
  output logic                         dp_squeeze_output,
  output logic                         dp_reset_ram,
  output logic                         dp_mux256,
  output logic [PARALLEL_SLICES-1:0]   dp_din
`ifdef KECCAK_SEQ_PERF_EN
  ,
  output logic [31:0]                  perf_cycles,
  output logic [7:0]                   perf_perms
`endif
);

  localparam logic [COUNTER_WIDTH-1:0] RATE128_LAST = COUNTER_WIDTH'(1344 / PARALLEL_SLICES - 1);
  localparam logic [COUNTER_WIDTH-1:0] RATE256_LAST = COUNTER_WIDTH'(1088 / PARALLEL_SLICES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CUST_LAST    = COUNTER_WIDTH'(64 / PARALLEL_SLICES - 1);
  localparam logic [COUNTER_WIDTH-1:0] SUB_LAST     = COUNTER_WIDTH'(WOUT / PARALLEL_SLICES - 1);
  localparam logic [ROUND_COUNT_WIDTH-1:0] ROUND_LAST =
    ROUND_COUNT_WIDTH'(NUM_SUB_ROUNDS * KECCAK_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_CUST, S_ABSORB, S_PERM, S_SQUEEZE
  } state_t;

  state_t                       state_q, state_d;
  logic [COUNTER_WIDTH-1:0]     reads_q, reads_d;
  logic [COUNTER_WIDTH-1:0]     sub_q, sub_d;
  logic [ROUND_COUNT_WIDTH-1:0] round_q, round_d;
  logic [7:0]                   blocks_q, blocks_d;
  logic                         bof_q, bof_d;
  logic                         mode_q, mode_d;
  logic                         cust_q, cust_d;
  logic                         last_q, last_d;
  logic                         flush_q, flush_d;
  logic                         ov_q, ov_d;
  logic [COUNTER_WIDTH-1:0]     rate_last;

  assign rate_last = mode_q ? RATE256_LAST : RATE128_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      reads_q  <= '0;
      sub_q    <= '0;
      round_q  <= '0;
      blocks_q <= '0;
      bof_q    <= 1'b0;
      mode_q   <= 1'b0;
      cust_q   <= 1'b0;
      last_q   <= 1'b0;
      flush_q  <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reads_q  <= reads_d;
      sub_q    <= sub_d;
      round_q  <= round_d;
      blocks_q <= blocks_d;
      bof_q    <= bof_d;
      mode_q   <= mode_d;
      cust_q   <= cust_d;
      last_q   <= last_d;
      flush_q  <= flush_d;
      ov_q     <= ov_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    reads_d  = reads_q;
    sub_d    = sub_q;
    round_d  = round_q;
    blocks_d = blocks_q;
    bof_d    = bof_q;
    mode_d   = mode_q;
    cust_d   = cust_q;
    last_d   = last_q;
    flush_d  = flush_q;
    // The output word register empties when the consumer takes it.
    ov_d     = ov_q & ~out_ready;

    in_ready          = 1'b0;
    done              = 1'b0;
    dp_absorb_data    = 1'b0;
    dp_absorb_cust    = 1'b0;
    dp_computation_en = 1'b0;
    dp_squeeze_output = 1'b0;
    dp_reset_ram      = 1'b0;
    dp_din            = '0;
    busy              = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CLEAR;
          mode_d   = mode256;
          cust_d   = cust_en;
          blocks_d = (out_blocks == 8'd0) ? 8'd1 : out_blocks;
        end
      end
      S_CLEAR: begin
        dp_reset_ram = 1'b1;
        bof_d        = 1'b1;
        reads_d      = '0;
        sub_d        = '0;
        round_d      = '0;
        last_d       = 1'b0;
        flush_d      = 1'b0;
        state_d      = cust_q ? S_CUST : S_ABSORB;
      end
      S_CUST: begin
        in_ready       = 1'b1;
        dp_absorb_cust = in_valid;
        dp_din         = in_data;
        if (in_valid) begin
          if (reads_q == CUST_LAST) begin
            reads_d = '0;
            state_d = S_PERM;
          end else begin
            reads_d = reads_q + 1'b1;
          end
        end
      end
      S_ABSORB: begin
        in_ready       = 1'b1;
        dp_absorb_data = in_valid;
        dp_din         = in_data;
        if (in_valid) begin
          if (reads_q == rate_last || in_last) begin
            reads_d = '0;
            bof_d   = 1'b0;
            last_d  = last_q | in_last;
            state_d = S_PERM;
          end else begin
            reads_d = reads_q + 1'b1;
          end
        end
      end
      S_PERM: begin
        dp_computation_en = 1'b1;
        if (round_q == ROUND_LAST) begin
          round_d = '0;
          state_d = last_q ? S_SQUEEZE : S_ABSORB;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      S_SQUEEZE: begin
        dp_squeeze_output = 1'b1;
        if (flush_q) begin
          if (ov_q && out_ready) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (!ov_q || out_ready) begin
          // Reads only advance while the output register can take the next word.
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            ov_d  = 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
          if (reads_q == rate_last) begin
            reads_d = '0;
            if (blocks_q > 8'd1) begin
              blocks_d = blocks_q - 8'd1;
              state_d  = S_PERM;
            end else begin
              flush_d = 1'b1;
            end
          end else begin
            reads_d = reads_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = ov_q;
  assign dp_round  = round_q;
  assign dp_reads  = reads_q;
  assign dp_bof    = bof_q;
  assign dp_mux256 = mode_q & busy;

`ifdef KECCAK_SEQ_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [7:0]  perf_perms_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_perms_q  <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_cycles_q <= '0;
      perf_perms_q  <= '0;
    end else begin
      if (busy) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (state_q == S_PERM && round_q == ROUND_LAST && perf_perms_q != 8'hFF)
        perf_perms_q <= perf_perms_q + 8'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_perms  = perf_perms_q;
`endif

endmodule
